// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage core (IF/ID/EX/DM/WB).
//
// Tracks the destinations of instructions in EX and DM, registers the EX-stage
// forwarding selects as an instruction moves from ID into EX, and produces
// load-use stalls and branch/jump flush controls.
//
// Build option: define HAZARD_WB_FWD_EN for full forwarding (DM->EX and WB->EX).
// When it is undefined, FORW_SRC_WB is never produced; an ID source that matches
// the DM slot stalls one cycle and relies on register-file write-before-read.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1/id_rs2            source register indices
//   id_rs1_used/id_rs2_used  instruction reads that source
//   id_rd, id_reg_wen        destination index and write enable
//   id_is_load               instruction is a load
//   ex_redirect              taken branch/jump resolved in EX this cycle
//   forw_A_sel/forw_B_sel    registered forward selects for the instruction in EX
//   stall_if, stall_id       hold PC / hold IF/ID register
//   flush_id                 clear IF/ID register to NOP
//   bubble_ex                load NOP into ID/EX register on the next edge
//   stall_cnt, flush_cnt     saturating stall / flush cycle counters
module hazard_ctrl #(
  parameter int unsigned RF_AWIDTH = 5,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [RF_AWIDTH-1:0] id_rs1,
  input  logic [RF_AWIDTH-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [RF_AWIDTH-1:0] id_rd,
  input  logic                 id_reg_wen,
  input  logic                 id_is_load,
  input  logic                 ex_redirect,
  output logic [1:0]           forw_A_sel,
  output logic [1:0]           forw_B_sel,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic                 bubble_ex,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  // Encodings shared with CtrlCode.vh.
  typedef enum logic [1:0] {
    FORW_SRC_EX = 2'd0,
    FORW_SRC_DM = 2'd1,
    FORW_SRC_WB = 2'd2
  } forw_src_e;

  // Tracking slots. Each slot keeps "writes a non-zero rd" pre-reduced from
  // {valid, wen, rd!=0}, so a match is just wr && rd==src. The WB slot is not
  // stored: write-before-read makes a WB producer invisible to ID, and only the
  // EX slot's load flag ever matters.
  logic                 ex_wr, ex_load, dm_wr;
  logic [RF_AWIDTH-1:0] ex_rd, dm_rd;

  logic                 a_ex, a_dm, b_ex, b_dm;
  logic                 hz_a, hz_b, stall;
  logic [1:0]           sel_a, sel_b;

  // Returns {hazard, select} for one source; the EX-slot (youngest) producer wins.
  function automatic logic [2:0] resolve(input logic ex_m, input logic dm_m,
                                         input logic ex_is_load);
    logic       hz;
    logic [1:0] sel;
    hz  = 1'b0;
    sel = FORW_SRC_EX;
    if (ex_m) begin
      if (ex_is_load) hz  = 1'b1;
      else            sel = FORW_SRC_DM;
    end else if (dm_m) begin
`ifdef HAZARD_WB_FWD_EN
      sel = FORW_SRC_WB;
`else
      hz  = 1'b1;
`endif
    end
    return {hz, sel};
  endfunction

  always_comb begin
    a_ex = id_rs1_used && ex_wr && (ex_rd == id_rs1);
    a_dm = id_rs1_used && dm_wr && (dm_rd == id_rs1);
    b_ex = id_rs2_used && ex_wr && (ex_rd == id_rs2);
    b_dm = id_rs2_used && dm_wr && (dm_rd == id_rs2);
    {hz_a, sel_a} = resolve(a_ex, a_dm, ex_load);
    {hz_b, sel_b} = resolve(b_ex, b_dm, ex_load);

    // Redirect wins over any stall; everything is quiet while in reset.
    stall     = !rst && id_valid && (hz_a || hz_b) && !ex_redirect;
    stall_if  = stall;
    stall_id  = stall;
    flush_id  = !rst && ex_redirect;
    bubble_ex = stall || flush_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wr      <= 1'b0;
      ex_load    <= 1'b0;
      ex_rd      <= '0;
      dm_wr      <= 1'b0;
      dm_rd      <= '0;
      forw_A_sel <= FORW_SRC_EX;
      forw_B_sel <= FORW_SRC_EX;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      dm_wr <= ex_wr;
      dm_rd <= ex_rd;
      if (bubble_ex || !id_valid) begin
        ex_wr      <= 1'b0;
        ex_load    <= 1'b0;
        ex_rd      <= '0;
        forw_A_sel <= FORW_SRC_EX;
        forw_B_sel <= FORW_SRC_EX;
      end else begin
        ex_wr      <= id_reg_wen && (id_rd != '0);
        ex_load    <= id_is_load;
        ex_rd      <= id_rd;
        forw_A_sel <= sel_a;
        forw_B_sel <= sel_b;
      end
      if (stall_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
